data_memory_port: RTL

Load/store responder on RAM port b of the CPU: accepts one 8/16/32-bit load or store at a time from the load-store queue and converts it into 128-bit line accesses on `addr_b`/`dout_b`/`din_b`/`we_b`. Loads are line read plus lane extract and sign/zero extension. Stores are read-modify-write: the block reads the line, merges the bytes, then writes the line back. It is the data-side counterpart of the instruction cache on port a.

---
 rtl/data_memory_port_if.sv | 39 +++
 rtl/data_memory_port.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_port_if.sv
// data_memory_port_if
//   Request/response bundle between the load-store queue and the data
//   memory port.
//   master : load-store queue side (drives requests and flush, sees ready/response)
//   slave  : data_memory_port side
//   Signals:
//     req_valid/req_ready  request handshake
//     req_write            1 = store, 0 = load
//     req_size             0 = byte, 1 = half, 2/3 = word
//     req_signed           sign-extend load result
//     req_addr             byte address
//     req_wdata            store data (low bytes used)
//     flush                abort a pending load
//     resp_valid           one-cycle completion pulse
//     resp_data            extended load data, 0 for stores
interface data_memory_port_if #(
  parameter int ADDR_WIDTH = 17
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  flush;
  logic                  resp_valid;
  logic [31:0]           resp_data;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, flush,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, flush,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/data_memory_port.sv
// data_memory_port
//   Single-outstanding load/store responder on RAM port b. Loads read a
//   128-bit line and extract/extend the addressed lane; stores read the
//   line, merge the new bytes and write the line back.
//   Ports:
//     clk      clock, rising edge
//     rst      asynchronous reset, active low
//     rdy      global enable; 0 freezes all state
//     bus      request/response interface (slave side)
//     dout_b   line read data, valid the cycle after addr_b
//     addr_b   registered line-aligned address
//     din_b    registered write line
//     we_b     write enable (gated by rdy)
module data_memory_port #(
  parameter int ADDR_WIDTH = 17,
  parameter int RAM_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  data_memory_port_if.slave     bus,
  input  logic [RAM_WIDTH-1:0]  dout_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [RAM_WIDTH-1:0]  din_b,
  output logic                  we_b
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] WR      = 2'd3;

  // Force the lane offset onto the natural boundary of the access size.
  function automatic logic [3:0] align_off(input logic [3:0] off, input logic [1:0] size);
    logic [3:0] res;
    case (size)
      2'd0:    res = off;
      2'd1:    res = {off[3:1], 1'b0};
      default: res = {off[3:2], 2'b00};
    endcase
    return res;
  endfunction

  // Pull the addressed lane out of a line and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [RAM_WIDTH-1:0] line,
                                               input logic [3:0] off,
                                               input logic [1:0] size,
                                               input logic sgn);
    logic [RAM_WIDTH-1:0] shifted;
    logic [31:0]          res;
    shifted = line >> {off, 3'b000};
    case (size)
      2'd0:    res = {{24{sgn & shifted[7]}}, shifted[7:0]};
      2'd1:    res = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: res = shifted[31:0];
    endcase
    return res;
  endfunction

  // Replace bytes off .. off+n-1 of a line with the low n bytes of wdata.
  function automatic logic [RAM_WIDTH-1:0] merge_store(input logic [RAM_WIDTH-1:0] line,
                                                       input logic [3:0] off,
                                                       input logic [1:0] size,
                                                       input logic [31:0] wdata);
    logic [RAM_WIDTH-1:0] res;
    logic [4:0]           rel;
    logic [4:0]           nbytes;
    case (size)
      2'd0:    nbytes = 5'd1;
      2'd1:    nbytes = 5'd2;
      default: nbytes = 5'd4;
    endcase
    res = line;
    for (int i = 0; i < RAM_WIDTH / 8; i++) begin
      // Bytes below off wrap to a large rel value and are left untouched.
      rel = 5'(i) - {1'b0, off};
      if (rel < nbytes) begin
        res[8*i +: 8] = wdata[{rel[1:0], 3'b000} +: 8];
      end else begin
        res[8*i +: 8] = line[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [1:0]            state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [3:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]  din_q, din_d;
  logic                  we_q, we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  accept_s;

  // Flush in IDLE also blocks acceptance in the same cycle.
  assign accept_s = (state_q == IDLE) & rdy & ~bus.flush;

  // Next-state and datapath logic; everything holds while rdy is low.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    din_d        = din_q;
    we_d         = we_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    if (rdy) begin
      resp_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && accept_s) begin
            write_d  = bus.req_write;
            size_d   = bus.req_size;
            signed_d = bus.req_signed;
            off_d    = align_off(bus.req_addr[3:0], bus.req_size);
            wdata_d  = bus.req_wdata;
            addr_d   = {bus.req_addr[ADDR_WIDTH-1:4], 4'b0000};
            state_d  = RD_ADDR;
          end else begin
            state_d  = IDLE;
          end
        end
        RD_ADDR: begin
          if (bus.flush && !write_q) begin
            state_d = IDLE;
          end else begin
            state_d = RD_DATA;
          end
        end
        RD_DATA: begin
          if (write_q) begin
            din_d        = merge_store(dout_b, off_q, size_q, wdata_q);
            we_d         = 1'b1;
            resp_valid_d = 1'b1;
            resp_data_d  = 32'h0000_0000;
            state_d      = WR;
          end else if (bus.flush) begin
            state_d      = IDLE;
          end else begin
            resp_data_d  = extract_load(dout_b, off_q, size_q, signed_q);
            resp_valid_d = 1'b1;
            state_d      = IDLE;
          end
        end
        WR: begin
          we_d    = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      off_q        <= 4'd0;
      wdata_q      <= 32'h0000_0000;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      we_q         <= we_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // A pending pulse or write is held in its flop and only shows once rdy returns.
  assign bus.req_ready  = accept_s;
  assign bus.resp_valid = resp_valid_q & rdy;
  assign bus.resp_data  = resp_data_q;
  assign addr_b         = addr_q;
  assign din_b          = din_q;
  assign we_b           = we_q & rdy;

endmodule
